// File: rtl/uart_byte_rx_pkg.sv
// Shared UART constants: baud codes/rates, oversampling points and the RX FSM states.
// The byte transmitter uses the same baud table so both directions agree on timing.
package uart_byte_rx_pkg;

    localparam int unsigned UART_OSR = 16;

    localparam logic [3:0] SAMPLE_A = 4'd7;
    localparam logic [3:0] SAMPLE_B = 4'd8;
    localparam logic [3:0] SAMPLE_C = 4'd9;

    localparam logic [2:0] BAUD_SEL_9600   = 3'd0;
    localparam logic [2:0] BAUD_SEL_19200  = 3'd1;
    localparam logic [2:0] BAUD_SEL_38400  = 3'd2;
    localparam logic [2:0] BAUD_SEL_57600  = 3'd3;
    localparam logic [2:0] BAUD_SEL_115200 = 3'd4;

    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_38400  = 38400;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Reload value for the oversample divider, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
        return (clk_freq + (UART_OSR * baud) / 2) / (UART_OSR * baud) - 1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk o_tick every DIV+1 clocks while enabled.
// Clearing realigns the phase to the caller's event (e.g. a start edge).
module uart_baud_tick
    import uart_byte_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [2:0] i_baud_set,
    output logic       o_tick
);

    localparam logic [15:0] DIV_9600   = 16'(calc_div(CLK_FREQ, BAUD_9600));
    localparam logic [15:0] DIV_19200  = 16'(calc_div(CLK_FREQ, BAUD_19200));
    localparam logic [15:0] DIV_38400  = 16'(calc_div(CLK_FREQ, BAUD_38400));
    localparam logic [15:0] DIV_57600  = 16'(calc_div(CLK_FREQ, BAUD_57600));
    localparam logic [15:0] DIV_115200 = 16'(calc_div(CLK_FREQ, BAUD_115200));

    logic [15:0] w_div;
    logic [15:0] r_cnt;

    always_comb begin
        w_div = DIV_9600;
        case (i_baud_set)
            BAUD_SEL_19200:  w_div = DIV_19200;
            BAUD_SEL_38400:  w_div = DIV_38400;
            BAUD_SEL_57600:  w_div = DIV_57600;
            BAUD_SEL_115200: w_div = DIV_115200;
            default:         w_div = DIV_9600;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt >= w_div) r_cnt <= '0;
            else                r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_tick = i_en & ~i_clr & (r_cnt == w_div);

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 16x oversampling, 2-of-3 majority per bit, glitch-rejecting
// start check and stop-bit framing check; rx_done pulses for good and bad frames.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned OSR      = UART_OSR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);

    localparam logic [3:0] LAST_TICK = 4'(OSR - 1);

    logic       r_rx_s1, r_rx_s2, r_rx_s3;
    logic [2:0] r_baud_sel;
    rx_state_t  r_state;
    logic       r_uart_state;
    logic [3:0] r_os_idx;
    logic [3:0] r_slot;
    logic       r_s7, r_s8;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_done, r_ferr;

    logic w_fall, w_start, w_tick, w_maj, w_eval;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rs232_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // Only an edge arms the receiver, so a line held low after a bad stop cannot retrigger.
    assign w_fall  = r_rx_s3 & ~r_rx_s2;
    assign w_start = (r_state == IDLE) & w_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_baud_sel <= '0;
        else if (w_start) r_baud_sel <= baud_set;
    end

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ)
    ) u_baud_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_start),
        .i_en       (r_uart_state),
        .i_baud_set (r_baud_sel),
        .o_tick     (w_tick)
    );

    assign w_maj  = maj3(r_s7, r_s8, r_rx_s2);
    assign w_eval = w_tick & (r_os_idx == SAMPLE_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_uart_state <= 1'b0;
            r_os_idx     <= '0;
            r_slot       <= '0;
            r_s7         <= 1'b1;
            r_s8         <= 1'b1;
            r_shift      <= '0;
            r_data       <= '0;
            r_done       <= 1'b0;
            r_ferr       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            if (r_state == IDLE) begin
                if (w_fall) begin
                    r_state      <= START;
                    r_uart_state <= 1'b1;
                    r_os_idx     <= '0;
                    r_slot       <= '0;
                end
            end else if (w_tick) begin
                r_os_idx <= r_os_idx + 4'd1;
                if (r_os_idx == LAST_TICK) r_slot <= r_slot + 4'd1;
                if (r_os_idx == SAMPLE_A)  r_s7 <= r_rx_s2;
                if (r_os_idx == SAMPLE_B)  r_s8 <= r_rx_s2;
                if (w_eval) begin
                    case (r_state)
                        START: begin
                            if (w_maj) begin
                                r_state      <= IDLE;
                                r_uart_state <= 1'b0;
                            end else begin
                                r_state <= DATA;
                            end
                        end
                        DATA: begin
                            r_shift <= {w_maj, r_shift[7:1]};
                            if (r_slot == 4'd8) r_state <= STOP;
                        end
                        STOP: begin
                            r_done       <= 1'b1;
                            r_ferr       <= ~w_maj;
                            if (w_maj) r_data <= r_shift;
                            r_state      <= IDLE;
                            r_uart_state <= 1'b0;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign data_byte  = r_data;
    assign rx_done    = r_done;
    assign frame_err  = r_ferr;
    assign uart_state = r_uart_state;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: frames are driven bit-by-bit on rs232_rx and
// every rx_done is matched against the expected byte/frame_err queued at send time.
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [2:0] baud_set = 3'd0;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    // Oversample periods in clocks at 50 MHz: round(50e6 / (16 * baud)).
    localparam int unsigned P9600   = 326;
    localparam int unsigned P115200 = 27;
    localparam int unsigned NO_ABORT = 32'hFFFF_FFFF;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned last_done_cyc = 0;

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_byte_rx #(
        .CLK_FREQ (50000000),
        .OSR      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs232_rx   (rs232_rx),
        .baud_set   (baud_set),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done) begin
                done_cnt      <= done_cnt + 1;
                last_done_cyc <= cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_rx_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("data_byte", {24'd0, data_byte}, {24'd0, mon_e.data});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e.ferr});
                end
            end else if (frame_err) begin
                chk("frame_err_without_done", 32'd1, 32'd0);
            end
        end
    end

    // inv_slot: slot whose os-sample 8 is inverted (-1 none); abort_at: clock index to stop driving.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned p,
                              input int inv_slot, input int unsigned abort_at);
        int unsigned bitlen;
        bitlen = 16 * p;
        for (int unsigned c = 0; c < 10 * bitlen; c++) begin
            int unsigned slot;
            int unsigned t;
            logic        v;
            if (c == abort_at) return;
            slot = c / bitlen;
            t    = c % bitlen;
            if (slot == 0)      v = 1'b0;
            else if (slot == 9) v = stop;
            else                v = d[slot-1];
            if (int'(slot) == inv_slot && 2 * t >= 17 * p && 2 * t < 19 * p) v = ~v;
            @(negedge clk);
            rs232_rx = v;
        end
    endtask

    task automatic wait_drain(input string tag, input int unsigned maxc);
        int unsigned n;
        n = 0;
        while ((sb.size() != 0 || uart_state) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, {31'd0, (sb.size() == 0 && !uart_state)}, 32'd1);
    endtask

    task automatic idle(input int unsigned n);
        rs232_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int unsigned t0;
        int unsigned n0;
        logic        seen;
        int unsigned n;

        repeat (5) @(negedge clk);
        chk("rst_data_byte",  {24'd0, data_byte},  32'h00);
        chk("rst_rx_done",    {31'd0, rx_done},    32'd0);
        chk("rst_frame_err",  {31'd0, frame_err},  32'd0);
        chk("rst_uart_state", {31'd0, uart_state}, 32'd0);
        rst_n = 1'b1;
        idle(20);

        // 9600 baud, good frame, latency from start edge to rx_done
        baud_set = 3'd0;
        n0 = done_cnt;
        t0 = cyc;
        sb.push_back('{8'h7A, 1'b0});
        send_frame(8'h7A, 1'b1, P9600, -1, NO_ABORT);
        idle(2);
        wait_drain("b9600", 2000);
        chk("b9600_done_count", done_cnt - n0, 32'd1);
        chk("b9600_latency", {31'd0, (last_done_cyc - t0 >= 48000 && last_done_cyc - t0 <= 51000)}, 32'd1);
        idle(20);

        // 3 us low glitch at 9600: busy briefly, rejected near mid-start
        n0 = done_cnt;
        t0 = cyc;
        seen = 1'b0;
        rs232_rx = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            seen = seen | uart_state;
        end
        rs232_rx = 1'b1;
        n = 0;
        while (uart_state && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_busy_seen", {31'd0, seen}, 32'd1);
        chk("glitch_abort_time", {31'd0, (!uart_state && cyc - t0 >= 2800 && cyc - t0 <= 3800)}, 32'd1);
        idle(50);
        chk("glitch_no_done", done_cnt - n0, 32'd0);
        chk("glitch_data_kept", {24'd0, data_byte}, 32'h7A);

        // 115200, back-to-back frames with a single stop bit each
        baud_set = 3'd4;
        idle(10);
        n0 = done_cnt;
        sb.push_back('{8'h55, 1'b0});
        sb.push_back('{8'hAA, 1'b0});
        send_frame(8'h55, 1'b1, P115200, -1, NO_ABORT);
        send_frame(8'hAA, 1'b1, P115200, -1, NO_ABORT);
        idle(2);
        wait_drain("b2b", 1000);
        chk("b2b_done_count", done_cnt - n0, 32'd2);
        idle(20);

        // stop bit low: rx_done + frame_err together, data_byte keeps 0xAA
        n0 = done_cnt;
        sb.push_back('{8'hAA, 1'b1});
        send_frame(8'h3C, 1'b0, P115200, -1, NO_ABORT);
        idle(2);
        wait_drain("badstop", 1000);
        idle(100);
        chk("badstop_done_count", done_cnt - n0, 32'd1);
        chk("badstop_data_kept", {24'd0, data_byte}, 32'hAA);

        // one inverted os-sample (tick 8 of d3) corrected by majority
        sb.push_back('{8'hF0, 1'b0});
        send_frame(8'hF0, 1'b1, P115200, 4, NO_ABORT);
        idle(2);
        wait_drain("vote", 1000);
        idle(20);

        // reset during d4, then a clean frame
        n0 = done_cnt;
        send_frame(8'h81, 1'b1, P115200, -1, 5 * 16 * P115200 + 8 * P115200);
        chk("pre_rst_busy", {31'd0, uart_state}, 32'd1);
        rst_n = 1'b0;
        rs232_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_data_byte",  {24'd0, data_byte},  32'h00);
        chk("midrst_rx_done",    {31'd0, rx_done},    32'd0);
        chk("midrst_frame_err",  {31'd0, frame_err},  32'd0);
        chk("midrst_uart_state", {31'd0, uart_state}, 32'd0);
        rst_n = 1'b1;
        idle(100);
        chk("midrst_no_done", done_cnt - n0, 32'd0);
        sb.push_back('{8'h81, 1'b0});
        send_frame(8'h81, 1'b1, P115200, -1, NO_ABORT);
        idle(2);
        wait_drain("post_rst", 1000);
        idle(10);
        chk("post_rst_data", {24'd0, data_byte}, 32'h81);
        chk("post_rst_done_count", done_cnt - n0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
